// File: rtl/reset_sequencer_if.sv
// Channel-reset bundle of one clock domain: software request in, synchronized and sequenced resets out.
interface reset_sequencer_if #(
  parameter int NUM_CH = 4
);
  logic              swrst_req_i;
  logic              rstn_sync_o;
  logic [NUM_CH-1:0] rstn_o;
  logic              seq_done_o;

  modport master (
    input  swrst_req_i,
    output rstn_sync_o,
    output rstn_o,
    output seq_done_o
  );

  modport slave (
    output swrst_req_i,
    input  rstn_sync_o,
    input  rstn_o,
    input  seq_done_o
  );
endinterface

// File: rtl/reset_sequencer.sv
// Reset synchronizer plus in-order channel release sequencer for one clock domain.
// Software reset is built only when RSTSEQ_SWRST_EN is defined; otherwise swrst_req_i is ignored.
module reset_sequencer #(
  parameter int SYNC_STAGES = 2,
  parameter int NUM_CH      = 4,
  parameter int HOLD_CYCLES = 16,
  parameter int GAP_CYCLES  = 8
) (
  input  logic                clk_i,
  input  logic                rstn_unsync_i,
  reset_sequencer_if.master   bus
);

  localparam int MAX_CYC = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int CW      = $clog2(MAX_CYC + 1);
  localparam int CHW     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic [1:0] {
    S_RESET,
    S_HOLD,
    S_GAP,
    S_DONE
  } state_t;

  logic [SYNC_STAGES-1:0] sync_reg;
  state_t                 state_reg, state_next;
  logic [CW-1:0]          cnt_reg, cnt_next;
  logic [CHW-1:0]         ch_reg, ch_next;
  logic [NUM_CH-1:0]      rstn_reg, rstn_next;
  logic                   done_reg, done_next;

  always_ff @(posedge clk_i or negedge rstn_unsync_i) begin
    if (!rstn_unsync_i) begin
      sync_reg <= '0;
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], 1'b1};
    end
  end

  always_ff @(posedge clk_i or negedge rstn_unsync_i) begin
    if (!rstn_unsync_i) begin
      state_reg <= S_RESET;
      cnt_reg   <= '0;
      ch_reg    <= '0;
      rstn_reg  <= '0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      ch_reg    <= ch_next;
      rstn_reg  <= rstn_next;
      done_reg  <= done_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    ch_next    = ch_reg;
    rstn_next  = rstn_reg;
    done_next  = done_reg;

    case (state_reg)
      S_RESET: begin
        if (sync_reg[SYNC_STAGES-1]) begin
          state_next = S_HOLD;
          cnt_next   = '0;
        end
      end
      S_HOLD: begin
        if (cnt_reg == CW'(HOLD_CYCLES - 1)) begin
          rstn_next[0] = 1'b1;
          cnt_next     = '0;
          ch_next      = CHW'(1);
          if (NUM_CH == 1) begin
            state_next = S_DONE;
            done_next  = 1'b1;
          end else begin
            state_next = S_GAP;
          end
        end else begin
          cnt_next = cnt_reg + CW'(1);
        end
      end
      S_GAP: begin
        if (cnt_reg == CW'(GAP_CYCLES - 1)) begin
          rstn_next[ch_reg] = 1'b1;
          cnt_next          = '0;
          // The last channel's release and the done flag share one edge.
          if (ch_reg == CHW'(NUM_CH - 1)) begin
            state_next = S_DONE;
            done_next  = 1'b1;
          end else begin
            ch_next = ch_reg + CHW'(1);
          end
        end else begin
          cnt_next = cnt_reg + CW'(1);
        end
      end
      S_DONE: begin
      end
      default: begin
        state_next = S_RESET;
      end
    endcase

`ifdef RSTSEQ_SWRST_EN
    // Software reset overrides any release scheduled on the same edge.
    if (bus.swrst_req_i && (state_reg != S_RESET)) begin
      rstn_next  = '0;
      done_next  = 1'b0;
      state_next = S_HOLD;
      cnt_next   = '0;
    end
`endif
  end

`ifndef RSTSEQ_SWRST_EN
  logic unused_swrst;
  assign unused_swrst = bus.swrst_req_i;
`endif

  assign bus.rstn_sync_o = sync_reg[SYNC_STAGES-1];
  assign bus.rstn_o      = rstn_reg;
  assign bus.seq_done_o  = done_reg;

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: power-on table, directed corner sequences and randomized run against an edge-count model.
module tb_reset_sequencer;
  localparam int SYNC = 2;
  localparam int NCH  = 4;
  localparam int HOLD = 16;
  localparam int GAP  = 8;

  logic clk = 1'b0;
  logic rstn_unsync = 1'b1;
  int   checks = 0;
  int   passes = 0;
  int   ecount = 0;

  always #5 clk = ~clk;

  reset_sequencer_if #(.NUM_CH(NCH)) bus1 ();
  reset_sequencer_if #(.NUM_CH(1))   bus2 ();

  reset_sequencer #(.SYNC_STAGES(SYNC), .NUM_CH(NCH), .HOLD_CYCLES(HOLD), .GAP_CYCLES(GAP)) dut (
    .clk_i(clk), .rstn_unsync_i(rstn_unsync), .bus(bus1)
  );

  reset_sequencer #(.SYNC_STAGES(3), .NUM_CH(1), .HOLD_CYCLES(1), .GAP_CYCLES(1)) dut_corner (
    .clk_i(clk), .rstn_unsync_i(rstn_unsync), .bus(bus2)
  );

  // Model: every release is a fixed edge offset from the latest anchor (HOLD entry or software reset).
  int m_edges  = 0;
  int m_anchor = SYNC + 1;

  always @(posedge clk or negedge rstn_unsync) begin
    if (!rstn_unsync) begin
      m_edges  <= 0;
      m_anchor <= SYNC + 1;
    end else begin
      m_edges <= m_edges + 1;
`ifdef RSTSEQ_SWRST_EN
      if (bus1.swrst_req_i && (m_edges + 1 >= SYNC + 2)) m_anchor <= m_edges + 1;
`endif
    end
  end

  function automatic logic [5:0] model_out();
    logic [NCH-1:0] r;
    for (int k = 0; k < NCH; k++) r[k] = (m_edges >= m_anchor + HOLD + k * GAP);
    return {m_edges >= SYNC, r[NCH-1], r};
  endfunction

  function automatic logic [5:0] dut_out();
    return {bus1.rstn_sync_o, bus1.seq_done_o, bus1.rstn_o};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h (edge %0d, t=%0t)", nm, act, exp, ecount, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    ecount++;
    @(negedge clk);
  endtask

  typedef struct {
    int         e;
    logic       s;
    logic       d;
    logic [3:0] r;
    logic       c;
    logic       cs;
  } vec_t;

  vec_t tbl[14];

  task automatic run_table(input int upto);
    for (int i = 0; i < 14; i++) begin
      if (tbl[i].e > upto) break;
      while (ecount < tbl[i].e) tick();
      $display("edge %0d: sync=%0b done=%0b rstn=%04b corner=%0b", ecount,
               bus1.rstn_sync_o, bus1.seq_done_o, bus1.rstn_o, bus2.rstn_o[0]);
      chk("table_main", 32'(dut_out()), 32'({tbl[i].s, tbl[i].d, tbl[i].r}));
      chk("table_corner", 32'({bus2.rstn_sync_o, bus2.seq_done_o, bus2.rstn_o}),
          32'({tbl[i].cs, tbl[i].c, tbl[i].c}));
    end
  endtask

  task automatic release_reset();
    @(negedge clk);
    rstn_unsync = 1'b1;
    ecount = 0;
  endtask

`ifdef RSTSEQ_SWRST_EN
  int s_edge;
`endif

  initial begin
    tbl = '{
      '{1,  1'b0, 1'b0, 4'b0000, 1'b0, 1'b0},
      '{2,  1'b1, 1'b0, 4'b0000, 1'b0, 1'b0},
      '{3,  1'b1, 1'b0, 4'b0000, 1'b0, 1'b1},
      '{4,  1'b1, 1'b0, 4'b0000, 1'b0, 1'b1},
      '{5,  1'b1, 1'b0, 4'b0000, 1'b1, 1'b1},
      '{18, 1'b1, 1'b0, 4'b0000, 1'b1, 1'b1},
      '{19, 1'b1, 1'b0, 4'b0001, 1'b1, 1'b1},
      '{26, 1'b1, 1'b0, 4'b0001, 1'b1, 1'b1},
      '{27, 1'b1, 1'b0, 4'b0011, 1'b1, 1'b1},
      '{34, 1'b1, 1'b0, 4'b0011, 1'b1, 1'b1},
      '{35, 1'b1, 1'b0, 4'b0111, 1'b1, 1'b1},
      '{42, 1'b1, 1'b0, 4'b0111, 1'b1, 1'b1},
      '{43, 1'b1, 1'b1, 4'b1111, 1'b1, 1'b1},
      '{60, 1'b1, 1'b1, 4'b1111, 1'b1, 1'b1}
    };
    bus1.swrst_req_i = 1'b0;
    bus2.swrst_req_i = 1'b0;

    #1 rstn_unsync = 1'b0;
    #1;
    chk("reset_state", 32'(dut_out()), 32'h0);

    release_reset();
    run_table(1000);

    // Async drop mid-sequence, checked before any clock edge arrives.
    release_reset();
    rstn_unsync = 1'b0;
    release_reset();
    run_table(30);
    while (ecount < 30) tick();
    #1 rstn_unsync = 1'b0;
    #1;
    $display("async drop after edge 30: sync=%0b done=%0b rstn=%04b",
             bus1.rstn_sync_o, bus1.seq_done_o, bus1.rstn_o);
    chk("async_mid", 32'(dut_out()), 32'h0);
    chk("async_mid_corner", 32'({bus2.rstn_sync_o, bus2.seq_done_o, bus2.rstn_o}), 32'h0);
    release_reset();
    run_table(1000);

`ifdef RSTSEQ_SWRST_EN
    bus1.swrst_req_i = 1'b1;
    tick();
    bus1.swrst_req_i = 1'b0;
    s_edge = ecount;
    $display("swrst pulse at edge %0d: rstn=%04b done=%0b", s_edge, bus1.rstn_o, bus1.seq_done_o);
    chk("swrst_clear", 32'(dut_out()), 32'h20);
    for (int e = 1; e <= 41; e++) begin
      tick();
      chk("swrst_seq", 32'(dut_out()),
          32'({1'b1, e >= 40, e >= 40, e >= 32, e >= 24, e >= 16}));
    end

    bus1.swrst_req_i = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    bus1.swrst_req_i = 1'b0;
    s_edge = ecount;
    while (ecount < s_edge + 15) tick();
    chk("swrst_held_pre", 32'(dut_out()), 32'h20);
    tick();
    $display("held swrst: edge S+16 rstn=%04b", bus1.rstn_o);
    chk("swrst_held_rel", 32'(dut_out()), 32'h21);

    // Request lands on the rstn[1] release edge.
    while (ecount < s_edge + 23) tick();
    bus1.swrst_req_i = 1'b1;
    tick();
    bus1.swrst_req_i = 1'b0;
    s_edge = ecount;
    $display("colliding swrst: rstn=%04b", bus1.rstn_o);
    chk("swrst_collide", 32'(dut_out()), 32'h20);
    while (ecount < s_edge + 15) tick();
    chk("swrst_collide_pre", 32'(dut_out()), 32'h20);
    tick();
    chk("swrst_collide_rel", 32'(dut_out()), 32'h21);
    for (int i = 0; i < 30; i++) tick();
    chk("swrst_done_again", 32'(dut_out()), 32'h3f);
`else
    for (int i = 0; i < 120; i++) begin
      bus1.swrst_req_i = 1'($urandom_range(0, 1));
      tick();
      chk("swrst_ignored", 32'(dut_out()), 32'h3f);
    end
    bus1.swrst_req_i = 1'b0;
    $display("swrst toggled 120 cycles in DONE: rstn=%04b done=%0b", bus1.rstn_o, bus1.seq_done_o);
`endif

    // Randomized run against the model.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        bus1.swrst_req_i = 1'b0;
        #1 rstn_unsync = 1'b0;
        #1;
        $display("random async reset at iteration %0d", i);
        chk("rand_async", 32'(dut_out()), 32'(model_out()));
        for (int j = 0; j < int'($urandom_range(1, 3)); j++) tick();
        rstn_unsync = 1'b1;
      end else begin
        bus1.swrst_req_i = ($urandom_range(0, 11) == 0);
      end
      tick();
      chk("rand_model", 32'(dut_out()), 32'(model_out()));
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/reset_sequencer.md
# reset_sequencer

Parametrised multi-channel reset synchronizer and sequencer. Asserts all channel resets asynchronously and releases them synchronously to `clk_i`. After a minimum hold time, the channels are released one at a time in index order with a fixed gap between releases, so downstream subsystems leave reset in a defined sequence. Sits at the top of each clock domain and feeds every per-subsystem reset in that domain.

## Interface
- `SYNC_STAGES`, 2: synchronizer flop count; legal ≥2.
- `NUM_CH`, 4: number of sequenced reset outputs; legal 1..32.
- `HOLD_CYCLES`, 16: cycles from synchronized release (or software reset) to channel 0 release; legal ≥1.
- `GAP_CYCLES`, 8: cycles between consecutive channel releases; legal ≥1.

Ports:
- `clk_i` in 1: domain clock.
- `rstn_unsync_i` in 1: reset, asynchronous, active-low.
- `swrst_req_i` in 1: software reset request, synchronous to `clk_i`, active-high level.
- `rstn_sync_o` out 1: last synchronizer stage; plain synchronized reset.
- `rstn_o` out NUM_CH: sequenced active-low channel resets.
- `seq_done_o` out 1: high once all channels are released.

## Operation
- Synchronizer:
  - All `SYNC_STAGES` flops are async-cleared by `rstn_unsync_i` low.
  - Otherwise stage 0 loads 1 and each later stage loads the previous one.
  - `rstn_sync_o` is the last stage.
- Counter:
  - Width is `$clog2(max(HOLD_CYCLES,GAP_CYCLES)+1)`.
  - It never wraps; it is cleared on every state entry.
- FSM states:
  - **RESET**:
    - Entered asynchronously while `rstn_unsync_i` is low.
    - Moves to HOLD on the first edge where `rstn_sync_o` is sampled high, with cnt=0.
  - **HOLD**:
    - cnt increments each edge.
    - At the edge where cnt==HOLD_CYCLES-1: `rstn_o[0]`<=1, cnt<=0, ch<=1.
    - If NUM_CH==1, go to DONE; otherwise go to GAP.
  - **GAP**:
    - cnt increments each edge.
    - At the edge where cnt==GAP_CYCLES-1: `rstn_o[ch]`<=1, cnt<=0, ch<=ch+1.
    - If ch==NUM_CH-1, go to DONE in the same edge and set `seq_done_o`<=1.
  - **DONE**: holds; all `rstn_o` are high.
- Software reset:
  - When `swrst_req_i` is sampled high in any state except RESET: all `rstn_o`<=0, `seq_done_o`<=0, state<=HOLD, cnt<=0.
  - This takes priority over any release on the same edge.
  - While held high, the block re-enters HOLD with cnt=0 every cycle.
  - `rstn_sync_o` is unaffected.
- Async reset mid-sequence:
  - Takes effect immediately: all `rstn_o`=0, `seq_done_o`=0, synchronizer cleared, state=RESET, regardless of edge.
- A released channel never re-asserts except through async reset or software reset.

## Timing
- Reset values:
  - `rstn_sync_o`=0, `rstn_o`=all 0, `seq_done_o`=0.
  - Assertion is combinationally asynchronous, with no clock needed.
- Edge numbering: `rstn_unsync_i` rises before edge 1 with setup met.
  - `rstn_sync_o` rises at edge SYNC_STAGES.
  - HOLD is entered at edge SYNC_STAGES+1.
  - `rstn_o[k]` rises at edge SYNC_STAGES+1+HOLD_CYCLES+k·GAP_CYCLES.
  - `seq_done_o` rises on the same edge as `rstn_o[NUM_CH-1]`.
- Software reset: with `swrst_req_i` last sampled high at edge S, `rstn_o[k]` rises at edge S+HOLD_CYCLES+k·GAP_CYCLES.
- All outputs are registered; there is no combinational path from `swrst_req_i` to outputs.

## Configuration
- Macro: `RSTSEQ_SWRST_EN`.
- Defined: software reset behaves as described above.
- Undefined:
  - `swrst_req_i` remains a port but is ignored, and no logic is generated for it.
  - Reset can then come only from `rstn_unsync_i`.

## Test plan
- Power-on, defaults (2/4/16/8):
  - Release `rstn_unsync_i` before edge 1 → `rstn_sync_o`↑ edge 2.
  - `rstn_o[0..3]`↑ edges 19/27/35/43.
  - `seq_done_o`↑ edge 43.
- Async reset mid-sequence: drop `rstn_unsync_i` between edges 30 and 31 → `rstn_o`=4'b0000 and `seq_done_o`=0 immediately, with no clock. Re-release reproduces the full power-on timing.
- Software reset in DONE: `swrst_req_i` high for 1 cycle, sampled at edge S → all `rstn_o` 0 after S, `seq_done_o`=0. Then `rstn_o[0..3]`↑ at S+16/24/32/40, and `rstn_sync_o` stays 1 throughout.
- Held and colliding software reset:
  - `swrst_req_i` held high 5 cycles (last sample S) → release timing is counted from S.
  - `swrst_req_i` coinciding with the `rstn_o[1]` release edge → `rstn_o[1]` stays 0.
- Corner parameters: NUM_CH=1, HOLD_CYCLES=1, SYNC_STAGES=3 → `rstn_o[0]` and `seq_done_o`↑ together at edge 5.
- Macro undefined: toggling `swrst_req_i` in DONE → no output change for ≥100 cycles.
